ram_bist_master: RTL and testbench

Initiator for the byte-addressable single-port RAM valid/ready interface. It drives `valid`/`wr_rd`/`addr`/`din` into the RAM and consumes `ready`/`dout`. On `start` it writes a seeded pattern across the whole address range, reads every location back, compares, and reports pass/fail, error count, first failing address and handshake timeout. It sits beside the RAM as its built-in self-test engine and as the reusable bus master for bring-up.

---
 rtl/ram_bist_master.sv | 128 ++++++++++++
 tb/tb_ram_bist_master.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_master.sv
// ram_bist_master: built-in self-test engine and reusable bus master for a
// byte-addressable single-port RAM with a valid/ready request interface.
//
// On start it writes expected(a) = a ^ seed to every address, reads every
// address back, compares the data and reports the result.
//
// Ports:
//   clk, rst           clock (rising edge), async active-high reset
//   start, seed        run request (IDLE only) and pattern seed
//   busy, done         run in progress / one-cycle end-of-run pulse
//   pass, timeout      result flags, held until the next accepted start
//   err_count          number of miscompares in the last run
//   first_err_addr     address of the first miscompare (valid if err_count != 0)
//   valid, wr_rd       RAM request (wr_rd: 1 = write, 0 = read)
//   addr, din          RAM address / write data
//   ready, dout        RAM accept/complete and read data (same-cycle)
module ram_bist_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] din,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] dout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] seed_q;
  logic [DATA_WIDTH-1:0] expected;
  logic [CW-1:0]         wait_cnt;
  logic                  hs, last, tmo_hit, mismatch, accept;

  // Request outputs derive straight from the state register, so addr/din/wr_rd
  // only move when addr or the state moves, i.e. on a handshake.
  assign valid    = (state == WR) || (state == RD);
  assign wr_rd    = (state == WR);
  assign busy     = (state != IDLE);
  assign expected = DATA_WIDTH'(addr) ^ seed_q;
  assign din      = wr_rd ? expected : '0;

  assign hs       = valid && ready;
  assign last     = (addr == '1);
  // The edge that would bring the wait count to TIMEOUT aborts the run.
  assign tmo_hit  = valid && !ready && (wait_cnt == CW'(TIMEOUT - 1));
  assign mismatch = hs && !wr_rd && (dout != expected);
  // done is high in the cycle after FIN; a start there is still part of the
  // finished run's tail and is ignored.
  assign accept   = (state == IDLE) && start && !done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = WR;
      WR: begin
        if (tmo_hit)        state_nx = FIN;
        else if (hs && last) state_nx = RD;
      end
      RD: begin
        if (tmo_hit)        state_nx = FIN;
        else if (hs && last) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_q         <= '0;
      addr           <= '0;
      wait_cnt       <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= (state == FIN);
      if (accept) begin
        seed_q         <= seed;
        addr           <= '0;
        wait_cnt       <= '0;
        err_count      <= '0;
        first_err_addr <= '0;
        pass           <= 1'b0;
        timeout        <= 1'b0;
      end
      if (valid) begin
        if (hs) begin
          // Wraps to 0 after the last write so reads start at address 0.
          addr     <= addr + 1'b1;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
          if (tmo_hit) timeout <= 1'b1;
        end
      end
      if (mismatch) begin
        err_count <= err_count + 1'b1;
        if (err_count == '0) first_err_addr <= addr;
      end
      if (state == FIN) pass <= (err_count == '0) && !timeout;
    end
  end

endmodule

// File: tb/tb_ram_bist_master.sv
// Self-checking bench for ram_bist_master: ideal RAM model with optional
// read-data faults, stall and no-ready modes; a scoreboard of expected RAM
// transactions is filled when a run is launched and drained on handshakes.
module tb_ram_bist_master;
  localparam int N = 16;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       busy, done, pass, timeout, valid, wr_rd, ready;
  logic [4:0] err_count;
  logic [3:0] first_err_addr, addr;
  logic [7:0] din, dout;

  always #5 clk = ~clk;

  ram_bist_master #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_addr(first_err_addr), .valid(valid), .wr_rd(wr_rd), .addr(addr),
    .din(din), .ready(ready), .dout(dout)
  );

  // RAM model
  logic [7:0] mem [N];
  int  wcount = 0;
  bit  stall_mode = 0, ready_on = 1, flip_en = 0;
  int  scnt;

  always @(posedge clk)
    if (valid && ready && wr_rd) begin
      mem[addr] <= din;
      wcount    <= wcount + 1;
    end

  always @(posedge clk or posedge rst)
    if (rst)                 scnt <= 0;
    else if (valid && !ready) scnt <= scnt + 1;
    else                     scnt <= 0;

  assign ready = stall_mode ? (scnt == 2) : ready_on;
  assign dout  = mem[addr] ^ {7'd0, flip_en && (addr == 4'd3 || addr == 4'd9)};

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: {wr_rd, addr, write data (0 for reads)}
  logic [12:0] sbq[$];
  logic [12:0] prev, exp_t;
  bit          prev_wait = 0;

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (prev_wait) chk("stall_stable", {wr_rd, addr, din}, prev);
      prev      <= {wr_rd, addr, din};
      prev_wait <= !ready;
      if (ready) begin
        exp_t = (sbq.size() != 0) ? sbq.pop_front() : 13'bx;
        chk("sb_txn", {wr_rd, addr, wr_rd ? din : 8'h00}, exp_t);
      end
    end else begin
      prev_wait <= 1'b0;
    end
  end

  task automatic push_run(input logic [7:0] sd);
    for (int a = 0; a < N; a++) sbq.push_back({1'b1, 4'(a), 8'(a) ^ sd});
    for (int a = 0; a < N; a++) sbq.push_back({1'b0, 4'(a), 8'h00});
  endtask

  task automatic kick(input logic [7:0] sd, input string tag);
    @(negedge clk); seed = sd; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk({tag, "_e0"}, {busy, valid, wr_rd, addr}, {3'b111, 4'h0});
  endtask

  // Counts edges after E0 (starting after edge 'from') until done is seen.
  task automatic wait_done(input string tag, input int exp_edge, input int from,
                           input int plo, input int phi);
    int got = -1;
    for (int k = from + 1; k <= 400 && got < 0; k++) begin
      @(posedge clk); #1;
      start = (k >= plo && k <= phi);
      if (done) got = k;
    end
    start = 1'b0;
    chk({tag, "_done_edge"}, got, exp_edge);
  endtask

  task automatic check_result(input string tag, input bit ep, input bit et,
                              input int ee, input int ef);
    chk({tag, "_pass"}, pass, ep);
    chk({tag, "_timeout"}, timeout, et);
    chk({tag, "_err_count"}, err_count, ee);
    if (ee != 0) chk({tag, "_first_err"}, first_err_addr, ef);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_sb_left"}, sbq.size(), 0);
  endtask

  task automatic done_low(input string tag);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {done, busy, valid}, 3'b000);
  endtask

  int w0;
  bit found;

  initial begin
    // reset
    #12;
    chk("reset_outputs", {busy, done, pass, timeout, err_count, first_err_addr,
                          valid, wr_rd, addr, din}, 27'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, valid}, 2'b00);

    // clean run, ready tied high
    push_run(8'hA5); kick(8'hA5, "t1");
    wait_done("t1", 33, 0, 0, 0);
    check_result("t1", 1, 0, 0, 0);
    chk("t1_mem0", mem[0], 8'hA5);
    chk("t1_mem15", mem[15], 8'hAA);
    done_low("t1");

    // read-data faults at addresses 3 and 9
    flip_en = 1;
    push_run(8'h00); kick(8'h00, "t2");
    wait_done("t2", 33, 0, 0, 0);
    check_result("t2", 0, 0, 2, 3);
    done_low("t2");
    flip_en = 0;

    // two stall cycles before every acceptance
    stall_mode = 1;
    push_run(8'h5A); kick(8'h5A, "t3");
    wait_done("t3", 97, 0, 0, 0);
    check_result("t3", 1, 0, 0, 0);
    done_low("t3");
    stall_mode = 0;

    // ready never comes: handshake timeout
    ready_on = 0; w0 = wcount;
    kick(8'h33, "t4");
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      if (k == 14) chk("t4_valid_e14", valid, 1);
      if (k == 15) chk("t4_drop_e15", {valid, timeout}, 2'b01);
    end
    wait_done("t4", 16, 15, 0, 0);
    check_result("t4", 0, 1, 0, 0);
    chk("t4_no_writes", wcount - w0, 0);
    done_low("t4");
    ready_on = 1;

    // reset in the middle of the read phase, then a clean rerun
    push_run(8'h11); kick(8'h11, "t5");
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (valid && !wr_rd && addr == 4'd7) found = 1;
    end
    chk("t5_reach_rd7", found, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_reset_outputs", {busy, done, pass, timeout, err_count, first_err_addr,
                             valid, wr_rd, addr, din}, 27'd0);
    sbq.delete();
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_no_resume", {busy, valid}, 2'b00);
    push_run(8'h3C); kick(8'h3C, "t5b");
    wait_done("t5b", 33, 0, 0, 0);
    check_result("t5b", 1, 0, 0, 0);
    done_low("t5b");

    // start pulsed while busy and on the done cycle: exactly one run
    push_run(8'h77); kick(8'h77, "t6");
    wait_done("t6", 33, 0, 5, 8);
    check_result("t6", 1, 0, 0, 0);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("t6_start_on_done", {busy, valid, done}, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_single_run", {busy, valid}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
